// File: rtl/mem_write_checker.sv
// Snoops the data-memory write port and matches each write against a table of
// expected (address, data) entries; reports pass, or fail on timeout / ordered mismatch.

module mem_write_checker_entry #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0] i_dataadr,
  input  logic [DW-1:0] i_writedata,
  input  logic [AW-1:0] i_exp_addr,
  input  logic [DW-1:0] i_exp_data,
  output logic          o_addr_eq,
  output logic          o_data_eq
);
  assign o_addr_eq = (i_dataadr == i_exp_addr);
  assign o_data_eq = (i_writedata == i_exp_data);
endmodule

module mem_write_checker #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 1024,
  parameter int ORDERED    = 0,
  localparam int MCW = $clog2(NUM_CHECKS + 1),
  localparam int LIW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_enable,
  input  logic                     i_memwrite,
  input  logic [AW-1:0]            i_dataadr,
  input  logic [DW-1:0]            i_writedata,
  input  logic [NUM_CHECKS*AW-1:0] i_exp_addr,
  input  logic [NUM_CHECKS*DW-1:0] i_exp_data,
  input  logic [NUM_CHECKS-1:0]    i_exp_mask,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pass,
  output logic                     o_fail,
  output logic [1:0]               o_fail_code,
  output logic [NUM_CHECKS-1:0]    o_hit_vec,
  output logic [MCW-1:0]           o_match_count,
  output logic [31:0]              o_cycle_count,
  output logic [LIW-1:0]           o_last_hit_idx
);

  localparam logic [31:0] TO32 = 32'(TIMEOUT);
  localparam logic [1:0]  FC_NONE     = 2'b00;
  localparam logic [1:0]  FC_TIMEOUT  = 2'b01;
  localparam logic [1:0]  FC_MISMATCH = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [NUM_CHECKS-1:0]   r_hit_vec;
  logic [MCW-1:0]          r_match_count;
  logic [31:0]             r_cycle_count;
  logic [LIW-1:0]          r_last_hit_idx;
  logic [1:0]              r_fail_code;

  logic [NUM_CHECKS-1:0]   w_addr_eq;
  logic [NUM_CHECKS-1:0]   w_data_eq;
  logic [NUM_CHECKS-1:0]   w_set;
  logic [NUM_CHECKS-1:0]   w_hit_vec_upd;
  logic [LIW-1:0]          w_hit_idx;
  logic                    w_hit;
  logic                    w_mismatch;
  logic                    w_found;
  logic                    w_sample;
  logic                    w_all_hit;
  logic [31:0]             w_cc_inc;
  logic                    w_timeout;

  genvar g;
  generate
    for (g = 0; g < NUM_CHECKS; g++) begin : g_entry
      mem_write_checker_entry #(.AW(AW), .DW(DW)) u_entry (
        .i_dataadr   (i_dataadr),
        .i_writedata (i_writedata),
        .i_exp_addr  (i_exp_addr[g*AW +: AW]),
        .i_exp_data  (i_exp_data[g*DW +: DW]),
        .o_addr_eq   (w_addr_eq[g]),
        .o_data_eq   (w_data_eq[g])
      );
    end
  endgenerate

  assign w_sample = (r_state == S_RUN) && i_memwrite;

  // Entry selection: unordered takes the lowest free full match; ordered only
  // ever looks at the lowest un-hit entry (masked entries start pre-hit).
  always_comb begin
    w_set      = '0;
    w_hit_idx  = '0;
    w_mismatch = 1'b0;
    w_found    = 1'b0;
    if (ORDERED != 0) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (!w_found && !r_hit_vec[i]) begin
          w_found = 1'b1;
          if (w_sample && w_addr_eq[i]) begin
            if (w_data_eq[i]) begin
              w_set[i]  = 1'b1;
              w_hit_idx = LIW'(i);
            end else begin
              w_mismatch = 1'b1;
            end
          end
        end
      end
    end else begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (!w_found && w_sample && !r_hit_vec[i] && w_addr_eq[i] && w_data_eq[i]) begin
          w_found   = 1'b1;
          w_set[i]  = 1'b1;
          w_hit_idx = LIW'(i);
        end
      end
    end
  end

  assign w_hit         = |w_set;
  assign w_hit_vec_upd = r_hit_vec | w_set;
  assign w_all_hit     = &w_hit_vec_upd;
  assign w_cc_inc      = (r_cycle_count >= TO32) ? TO32 : r_cycle_count + 32'd1;
  assign w_timeout     = (w_cc_inc == TO32);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Completion beats mismatch beats timeout on the same edge.
  always_comb begin
    w_next_state = r_state;
    if (!i_enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_RUN;
        S_RUN: begin
          if (w_all_hit)                    w_next_state = S_PASS;
          else if (w_mismatch || w_timeout) w_next_state = S_FAIL;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    o_pass = 1'b0;
    o_fail = 1'b0;
    case (r_state)
      S_RUN:  o_busy = 1'b1;
      S_PASS: begin o_done = 1'b1; o_pass = 1'b1; end
      S_FAIL: begin o_done = 1'b1; o_fail = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_vec      <= '0;
      r_match_count  <= '0;
      r_cycle_count  <= '0;
      r_last_hit_idx <= '0;
      r_fail_code    <= FC_NONE;
    end else if (!i_enable) begin
      r_hit_vec      <= '0;
      r_match_count  <= '0;
      r_cycle_count  <= '0;
      r_last_hit_idx <= '0;
      r_fail_code    <= FC_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hit_vec      <= ~i_exp_mask;
          r_match_count  <= '0;
          r_cycle_count  <= '0;
          r_last_hit_idx <= '0;
          r_fail_code    <= FC_NONE;
        end
        S_RUN: begin
          r_cycle_count <= w_cc_inc;
          r_hit_vec     <= w_hit_vec_upd;
          if (w_hit) begin
            r_match_count  <= r_match_count + 1'b1;
            r_last_hit_idx <= w_hit_idx;
          end
          if (!w_all_hit) begin
            if (w_mismatch)     r_fail_code <= FC_MISMATCH;
            else if (w_timeout) r_fail_code <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fail_code    = r_fail_code;
  assign o_hit_vec      = r_hit_vec;
  assign o_match_count  = r_match_count;
  assign o_cycle_count  = r_cycle_count;
  assign o_last_hit_idx = r_last_hit_idx;

endmodule
